mod_n_counter: RTL

MOD_N_COUNTER -- requirements
Module: mod_n_counter

---
 rtl/mod_n_counter.sv | 72 +++++++
 1 files changed

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear, clamped load, wrap or saturate at the
// bounds, a registered one-cycle carry flag and a combinational terminal count.
module mod_n_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 14,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic at_top;
  logic at_bottom;
  logic [WIDTH-1:0] load_clamped;

  assign at_top    = (count == MAX_COUNT);
  assign at_bottom = (count == '0);

  // Comparing against MAX_COUNT rather than MODULUS keeps this correct when
  // MODULUS == 2**WIDTH and MODULUS itself does not fit in WIDTH bits.
  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      count     <= load_clamped;
      carry_out <= 1'b0;
    end else if (count_enable) begin
      if (up_down) begin
        if (at_top) begin
          if (SATURATE == 0) count <= '0;
          carry_out <= 1'b1;
        end else begin
          count     <= count + WIDTH'(1);
          carry_out <= 1'b0;
        end
      end else begin
        if (at_bottom) begin
          if (SATURATE == 0) count <= MAX_COUNT;
          carry_out <= 1'b1;
        end else begin
          count     <= count - WIDTH'(1);
          carry_out <= 1'b0;
        end
      end
    end else begin
      carry_out <= 1'b0;
    end
  end

  // Terminal count looks only at enable/direction, so a cascade sees it even
  // in a cycle where clear or load takes priority locally.
  assign tc   = count_enable & ((up_down & at_top) | (~up_down & at_bottom));
  assign zero = at_bottom;

endmodule
